// File: rtl/pair_serializer_pkg.sv
// Shared types and widths for the pair serializer: FSM state encoding and
// the fixed operand width of the downstream 2:1 mux.
package pair_serializer_pkg;

    localparam int WORD_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE_A,
        SHOW_A,
        SETTLE_B,
        SHOW_B
    } state_t;

endpackage

// File: rtl/pair_serializer_settle_counter.sv
// Loadable 4-bit down-counter that times the mux settle window of each phase.
// It stops at zero rather than wrapping.
module settle_counter
    import pair_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pair_serializer.sv
// Accepts an (A, B) operand pair and steers it through an external 8-bit 2:1
// mux, A first then B, waiting HOLD_CYCLES for the mux to settle each phase.
module pair_serializer
    import pair_serializer_pkg::*;
#(
    parameter int HOLD_CYCLES = 3,
    parameter int WIDTH       = WORD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] mux_a,
    output logic [WIDTH-1:0] mux_b,
    output logic             mux_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_phase,
    output logic             busy
);

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

    state_t state;
    logic   capture;
    logic   cnt_load;
    logic   cnt_dec;
    logic   cnt_zero;

    // A new pair may enter from IDLE, or straight out of SHOW_B so that
    // consecutive pairs stream without an idle bubble.
    assign in_ready = !reset && ((state == IDLE) || ((state == SHOW_B) && out_ready));
    assign capture  = in_valid && in_ready;
    assign cnt_load = capture || ((state == SHOW_A) && out_ready);
    assign cnt_dec  = (state == SETTLE_A) || (state == SETTLE_B);

    settle_counter u_settle_counter (
        .clk        (clk),
        .reset      (reset),
        .load       (cnt_load),
        .load_value (RELOAD),
        .dec        (cnt_dec),
        .zero       (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            mux_a     <= '0;
            mux_b     <= '0;
            mux_sel   <= 1'b1;
            out_valid <= 1'b0;
            out_phase <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (capture) begin
                        mux_a     <= in_a;
                        mux_b     <= in_b;
                        mux_sel   <= 1'b1;
                        out_phase <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SETTLE_A;
                    end
                end
                SETTLE_A: begin
                    if (cnt_zero) begin
                        out_valid <= 1'b1;
                        state     <= SHOW_A;
                    end
                end
                SHOW_A: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mux_sel   <= 1'b0;
                        out_phase <= 1'b0;
                        state     <= SETTLE_B;
                    end
                end
                SETTLE_B: begin
                    if (cnt_zero) begin
                        out_valid <= 1'b1;
                        state     <= SHOW_B;
                    end
                end
                SHOW_B: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        mux_sel   <= 1'b1;
                        out_phase <= 1'b1;
                        if (capture) begin
                            mux_a <= in_a;
                            mux_b <= in_b;
                            state <= SETTLE_A;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pair_serializer.sv
// Self-checking bench for pair_serializer driving a NAND-level 8-bit 2:1 mux
// model; per-cycle vector tables plus a scoreboard on every accepted word.
module tb_pair_serializer;

    localparam int HOLD = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in_a = 8'h00;
    logic [7:0] in_b = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] mux_a;
    logic [7:0] mux_b;
    logic       mux_sel;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_phase;
    logic       busy;

    logic       sel_n;
    logic [7:0] nand_a;
    logic [7:0] nand_b;
    logic [7:0] c_mux;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [7:0] exp_q[$];

    typedef struct {
        logic        rst;
        logic        iv;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        ordy;
        logic [1:0]  push;
        logic [20:0] exp;
    } vec_t;

    vec_t vecs[$];

    pair_serializer #(.HOLD_CYCLES(HOLD), .WIDTH(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mux_a     (mux_a),
        .mux_b     (mux_b),
        .mux_sel   (mux_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_phase (out_phase),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Gate-level mux21_8: c = NAND(NAND(a, sel), NAND(b, ~sel)), 7 ns per NAND.
    always @(mux_sel) sel_n <= #7 ~mux_sel;
    always @(mux_a or mux_sel) nand_a <= #7 ~(mux_a & {8{mux_sel}});
    always @(mux_b or sel_n) nand_b <= #7 ~(mux_b & {8{sel_n}});
    always @(nand_a or nand_b) c_mux <= #7 ~(nand_a & nand_b);

    // A word transfers at the coming posedge when valid and ready are both high.
    always @(negedge clk) begin
        logic [7:0] e;
        if (!reset && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL strobe: unexpected word c=%h at %0t, required none", c_mux, $time);
            end else begin
                e = exp_q.pop_front();
                if (c_mux !== e) begin
                    n_fail++;
                    $display("[TB] FAIL strobe: c=%h phase=%b at %0t, required %h", c_mux, out_phase, $time, e);
                end
            end
        end
    end

    function automatic vec_t mk(input logic rst, input logic iv, input logic [7:0] a,
                                input logic [7:0] b, input logic ordy, input logic [1:0] push,
                                input logic ir, input logic [7:0] ea, input logic [7:0] eb,
                                input logic sel, input logic v, input logic ph, input logic bsy);
        vec_t r;
        r.rst  = rst;
        r.iv   = iv;
        r.a    = a;
        r.b    = b;
        r.ordy = ordy;
        r.push = push;
        r.exp  = {ir, ea, eb, sel, v, ph, bsy};
        return r;
    endfunction

    task automatic applyStimulus(input vec_t v);
        reset     = v.rst;
        in_valid  = v.iv;
        in_a      = v.a;
        in_b      = v.b;
        out_ready = v.ordy;
        if (v.push[1]) exp_q.push_back(v.a);
        if (v.push[0]) exp_q.push_back(v.b);
    endtask

    task automatic checkOutput(input vec_t v, input string name);
        logic [20:0] act;
        @(posedge clk);
        #1;
        act = {in_ready, mux_a, mux_b, mux_sel, out_valid, out_phase, busy};
        n_cmp++;
        if (act !== v.exp) begin
            n_fail++;
            $display("[TB] FAIL %s: {ir,a,b,sel,v,ph,busy} got %b_%h_%h_%b%b%b%b required %b_%h_%h_%b%b%b%b",
                     name, act[20], act[19:12], act[11:4], act[3], act[2], act[1], act[0],
                     v.exp[20], v.exp[19:12], v.exp[11:4], v.exp[3], v.exp[2], v.exp[1], v.exp[0]);
        end
    endtask

    task automatic runTable(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkOutput(vecs[i], $sformatf("%s[%0d]", tag, i));
        end
        vecs.delete();
    endtask

    initial begin
        $display("[TB] pair_serializer bench, HOLD_CYCLES=%0d", HOLD);

        // Reset, release, then one pair A5/3C with out_ready held high.
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'h00, 8'h00, 1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 8'hA5, 8'h3C, 1, 2'b11, 0, 8'hA5, 8'h3C, 1, 0, 1, 1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'hA5, 8'h3C, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'hA5, 8'h3C, 1, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'hA5, 8'h3C, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'hA5, 8'h3C, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'hA5, 8'h3C, 1, 0, 1, 0));
        runTable("basic");

        // Reset during SETTLE_B: A is delivered, B must never appear.
        vecs.push_back(mk(0, 1, 8'h5A, 8'hC3, 1, 2'b10, 0, 8'h5A, 8'hC3, 1, 0, 1, 1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h5A, 8'hC3, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h5A, 8'hC3, 1, 1, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h5A, 8'hC3, 0, 0, 0, 1));
        vecs.push_back(mk(1, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h00, 8'h00, 1, 0, 1, 0));
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'h00, 8'h00, 1, 0, 1, 0));
        runTable("rst_settle_b");

        // Stall in SHOW_A for 5 cycles with ignored in_valid, then back-to-back pair in SHOW_B.
        vecs.push_back(mk(0, 1, 8'hA5, 8'h3C, 0, 2'b11, 0, 8'hA5, 8'h3C, 1, 0, 1, 1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'hA5, 8'h3C, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 0, 2'b00, 0, 8'hA5, 8'h3C, 1, 1, 1, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0, 1, 8'hFF, 8'hFF, 0, 2'b00, 0, 8'hA5, 8'h3C, 1, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'hA5, 8'h3C, 0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 8'h77, 8'h88, 0, 2'b00, 0, 8'hA5, 8'h3C, 0, 1, 0, 1));
        vecs.push_back(mk(0, 1, 8'h01, 8'hFE, 1, 2'b11, 0, 8'h01, 8'hFE, 1, 0, 1, 1));
        for (int i = 0; i < 2; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h01, 8'hFE, 1, 0, 1, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h01, 8'hFE, 1, 1, 1, 1));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 0, 8'h01, 8'hFE, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'h01, 8'hFE, 0, 1, 0, 1));
        vecs.push_back(mk(0, 0, 8'h00, 8'h00, 1, 2'b00, 1, 8'h01, 8'hFE, 1, 0, 1, 0));
        runTable("stall_b2b");

        // Every expected word must have been delivered.
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL drain: %0d words still pending, required 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
